// File: rtl/pattern_stream_scheduler.sv
// Streams a byte buffer into a pattern detector one byte per cycle and owns the
// ack stall handshake: each detection holds the byte, drops ack, logs and resumes.
module pattern_stream_scheduler #(
    parameter int DEPTH          = 32,
    parameter int ADDR_W         = 5,
    parameter int ACK_LOW_CYCLES = 2,
    parameter int DRAIN_CYCLES   = 2,
    parameter int CNT_W          = 6
) (
    input  logic              clk,
    input  logic              reset_sync,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              start,
    output logic [7:0]        det_data,
    output logic              det_ack,
    input  logic              det_found,
    output logic              busy,
    output logic              done,
    output logic              match_valid,
    output logic [CNT_W-1:0]  match_count,
    output logic [ADDR_W-1:0] last_match_idx
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_ACK_LOW = 3'd2,
        S_RECOVER = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int                TW         = 8;
    localparam logic [ADDR_W-1:0] ZERO_IDX   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [TW-1:0]     ACK_LAST   = TW'(ACK_LOW_CYCLES - 1);
    localparam logic [TW-1:0]     DRAIN_LAST = TW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_W'(1);
        end
    endfunction

    state_t            state_r;
    logic [ADDR_W-1:0] idx_r;
    logic [TW-1:0]     tmr_r;
    logic [7:0]        mem_r [DEPTH];

    logic              idle_s;
    logic              load_s;
    logic              start_s;
    logic [ADDR_W-1:0] next_idx_s;
    logic [7:0]        first_byte_s;

    // Qualify host strobes and pick byte 0 with write-through for a same-cycle load.
    always_comb begin
        idle_s     = (state_r == S_IDLE) || (state_r == S_DONE);
        load_s     = idle_s && load_we;
        start_s    = idle_s && start;
        next_idx_s = idx_r + ADDR_W'(1);
        if (load_s && (load_addr == ZERO_IDX)) begin
            first_byte_s = load_data;
        end else begin
            first_byte_s = mem_r[ZERO_IDX];
        end
    end

    // Buffer is left out of reset so a loaded pattern survives an aborted pass.
    always_ff @(posedge clk) begin
        if (load_s) begin
            mem_r[load_addr] <= load_data;
        end
    end

    // Sequencer; every detector-facing and status output is registered here.
    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            state_r        <= S_IDLE;
            idx_r          <= ZERO_IDX;
            tmr_r          <= {TW{1'b0}};
            det_data       <= 8'd0;
            det_ack        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            match_valid    <= 1'b0;
            match_count    <= {CNT_W{1'b0}};
            last_match_idx <= ZERO_IDX;
        end else begin
            done        <= 1'b0;
            match_valid <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    det_ack <= 1'b0;
                    busy    <= 1'b0;
                    if (start_s) begin
                        state_r     <= S_FEED;
                        idx_r       <= ZERO_IDX;
                        det_data    <= first_byte_s;
                        det_ack     <= 1'b1;
                        busy        <= 1'b1;
                        match_count <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FEED, S_DRAIN: begin
                    if (det_found) begin
                        state_r        <= S_ACK_LOW;
                        tmr_r          <= {TW{1'b0}};
                        det_ack        <= 1'b0;
                        last_match_idx <= idx_r;
                        match_count    <= sat_inc(match_count);
                        match_valid    <= 1'b1;
                    end else if (state_r == S_DRAIN) begin
                        if (tmr_r == DRAIN_LAST) begin
                            state_r <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            det_ack <= 1'b0;
                        end else begin
                            tmr_r <= tmr_r + TW'(1);
                        end
                    end else if (idx_r == LAST_IDX) begin
                        state_r <= S_DRAIN;
                        tmr_r   <= {TW{1'b0}};
                    end else begin
                        idx_r    <= next_idx_s;
                        det_data <= mem_r[next_idx_s];
                    end
                end
                S_ACK_LOW: begin
                    if (tmr_r == ACK_LAST) begin
                        state_r <= S_RECOVER;
                        det_ack <= 1'b1;
                    end else begin
                        tmr_r <= tmr_r + TW'(1);
                    end
                end
                S_RECOVER: begin
                    // The held byte leaves only after this ack-high cycle.
                    if (idx_r == LAST_IDX) begin
                        state_r <= S_DRAIN;
                        tmr_r   <= {TW{1'b0}};
                    end else begin
                        state_r  <= S_FEED;
                        idx_r    <= next_idx_s;
                        det_data <= mem_r[next_idx_s];
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_stream_scheduler.sv
// Scoreboard bench: each pass pushes its expected per-cycle trace and match log;
// a negedge monitor pops and compares against what the scheduler presents.
module tb_pattern_stream_scheduler;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset_sync;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              start;
    logic [7:0]        det_data;
    logic              det_ack;
    logic              det_found;
    logic              busy;
    logic              done;
    logic              match_valid;
    logic [CNT_W-1:0]  match_count;
    logic [ADDR_W-1:0] last_match_idx;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       ack;
        logic       bsy;
        logic       dn;
        bit         chk_data;
        int         cnt;
    } trace_t;

    typedef struct {
        int idx;
        int cnt;
    } match_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc_count = 0;
    int         pass_base = 0;
    bit         pass_active = 1'b0;
    int         last_cyc = 0;
    trace_t     trace_q[$];
    match_t     match_q[$];
    logic [7:0] mem_m [DEPTH];
    bit         found_at [int];

    pattern_stream_scheduler #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACK_LOW_CYCLES(2), .DRAIN_CYCLES(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_sync(reset_sync), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .det_data(det_data), .det_ack(det_ack),
        .det_found(det_found), .busy(busy), .done(done), .match_valid(match_valid),
        .match_count(match_count), .last_match_idx(last_match_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: match log and per-cycle trace are popped only when the DUT presents them.
    always @(negedge clk) begin
        match_t m;
        trace_t t;
        if (match_valid === 1'b1) begin
            check("match_expected", (match_q.size() > 0), 1);
            if (match_q.size() > 0) begin
                m = match_q.pop_front();
                check("match_idx", last_match_idx, m.idx);
                check("match_count", match_count, m.cnt);
            end
        end
        if (pass_active && trace_q.size() > 0 && trace_q[0].cyc == cyc_count - pass_base) begin
            t = trace_q.pop_front();
            if (t.chk_data) check($sformatf("data_c%0d", t.cyc), det_data, t.data);
            check($sformatf("ack_busy_done_c%0d", t.cyc), {det_ack, busy, done}, {t.ack, t.bsy, t.dn});
            if (t.dn) check("done_match_count", match_count, t.cnt);
        end
    end

    task automatic push_t(inout int n, input logic [7:0] d, input logic a, input logic b,
                          input logic dn, input bit cd, input int cnt);
        trace_t t;
        t.cyc = n; t.data = d; t.ack = a; t.bsy = b; t.dn = dn; t.chk_data = cd; t.cnt = cnt;
        trace_q.push_back(t);
        n++;
    endtask

    // Detection cycle, two ack-low cycles, one recover cycle, all holding the byte.
    task automatic stall(inout int n, input logic [7:0] d, input bit hold);
        found_at[n] = 1'b1;
        push_t(n, d, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        for (int i = 0; i < 2; i++) begin
            if (hold) found_at[n] = 1'b1;
            push_t(n, d, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        end
        push_t(n, d, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    endtask

    task automatic build(input logic [DEPTH-1:0] sel, input int drain_m, input bit hold);
        int n = 1;
        int cnt = 0;
        int d = 0;
        int dm = drain_m;
        int maxc = (1 << CNT_W) - 1;
        trace_q.delete();
        match_q.delete();
        found_at.delete();
        for (int k = 0; k < DEPTH; k++) begin
            if (sel[k]) begin
                cnt = (cnt < maxc) ? cnt + 1 : cnt;
                match_q.push_back('{k, cnt});
                stall(n, mem_m[k], hold);
            end else begin
                push_t(n, mem_m[k], 1'b1, 1'b1, 1'b0, 1'b1, 0);
            end
        end
        while (d < 2) begin
            if (d == 0 && dm > 0) begin
                dm--;
                cnt = (cnt < maxc) ? cnt + 1 : cnt;
                match_q.push_back('{DEPTH - 1, cnt});
                stall(n, mem_m[DEPTH-1], hold);
            end else begin
                push_t(n, mem_m[DEPTH-1], 1'b1, 1'b1, 1'b0, 1'b1, 0);
                d++;
            end
        end
        push_t(n, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, cnt);
        push_t(n, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
        last_cyc = n - 1;
    endtask

    task automatic run_pass(input logic [DEPTH-1:0] sel, input int drain_m, input bit hold,
                            input bit ld0, input logic [7:0] ld_val, input bit ignore_test);
        if (ld0) mem_m[0] = ld_val;
        build(sel, drain_m, hold);
        start = 1'b1;
        load_we = ld0;
        load_addr = 5'd0;
        load_data = ld_val;
        @(posedge clk); #1;
        start = 1'b0;
        load_we = 1'b0;
        pass_base = cyc_count - 1;
        pass_active = 1'b1;
        for (int n = 1; n <= last_cyc; n++) begin
            det_found = found_at.exists(n) ? found_at[n] : 1'b0;
            if (ignore_test && n == 5) begin
                start = 1'b1; load_we = 1'b1; load_addr = 5'd20; load_data = 8'hFF;
            end else begin
                start = 1'b0; load_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        det_found = 1'b0;
        start = 1'b0;
        load_we = 1'b0;
        pass_active = 1'b0;
        check("trace_consumed", trace_q.size(), 0);
        check("matches_consumed", match_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation limit reached, expected $finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        reset_sync = 1'b1; start = 1'b0; load_we = 1'b0; load_addr = 5'd0;
        load_data = 8'd0; det_found = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_sync = 1'b0;
        @(negedge clk);
        check("reset_outputs", {det_data, det_ack, busy, done, match_valid, match_count, last_match_idx}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) begin
            load_we = 1'b1;
            load_addr = ADDR_W'(i);
            load_data = 8'(i) ^ 8'hA5;
            mem_m[i] = 8'(i) ^ 8'hA5;
            @(posedge clk); #1;
        end
        load_we = 1'b0;

        run_pass(32'h0000_0000, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        run_pass(32'h0000_0400, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        run_pass(32'h0010_0400, 0, 1'b1, 1'b0, 8'h00, 1'b0);
        run_pass(32'h0000_02AA, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        run_pass(32'h8000_0000, 1, 1'b0, 1'b0, 8'h00, 1'b0);
        run_pass(32'h0000_0000, 0, 1'b0, 1'b1, 8'h3C, 1'b0);

        // Abort while byte 15 is presented.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("abort_byte15", det_data, mem_m[15]);
        #2 reset_sync = 1'b1;
        #1;
        check("abort_async_zero", {det_data, det_ack, busy, done, match_valid, match_count, last_match_idx}, 0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        @(posedge clk); #1 reset_sync = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("no_done_after_abort", seen, 0);
        @(posedge clk); #1;

        run_pass(32'h0000_0010, 0, 1'b0, 1'b0, 8'h00, 1'b1);
        run_pass(32'h0000_0000, 0, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pattern_stream_scheduler.md
Name: pattern_stream_scheduler

Overview:
- Sequences a byte stream from an internal buffer into the pattern detector (8-bit data, ack handshake, found_pattern response).
- Owns the ack stall protocol: on each detection it holds the current byte, pulses ack low, counts the match and logs its stream index, then resumes.
- Sits between the host/loader and the detector; replaces bench-driven feeding in the integrated design.

Parameters:
- DEPTH, 32, number of bytes in the stream buffer (power of two).
- ADDR_W, 5, log2(DEPTH).
- ACK_LOW_CYCLES, 2, cycles det_ack is held low after a detection (≥1).
- DRAIN_CYCLES, 2, cycles found is still monitored after the last byte is presented.
- CNT_W, 6, width of match_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_sync  in  1  asynchronous, active-high reset.
- load_we  in  1  buffer write strobe; honoured only when busy=0.
- load_addr  in  ADDR_W  buffer write address.
- load_data  in  8  buffer write data.
- start  in  1  single-cycle pulse; begins a pass from index 0 when busy=0.
- det_data  out  8  byte presented to the detector.
- det_ack  out  1  ack to the detector; 1 = stream advancing.
- det_found  in  1  found_pattern from the detector.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of a pass.
- match_valid  out  1  one-cycle pulse when a match is logged.
- match_count  out  CNT_W  matches in the current pass; saturates at 2^CNT_W-1.
- last_match_idx  out  ADDR_W  index of the byte presented when det_found was sampled high.

Behaviour:
- Reset (async, any state): FSM=IDLE; idx=0; det_data=0; det_ack=0; busy=0; done=0; match_valid=0; match_count=0; last_match_idx=0. Buffer contents are not cleared.
- A reset mid-pass aborts immediately; no done pulse is issued.
- IDLE:
  - det_ack=0.
  - Loads write mem[load_addr]=load_data.
  - start → FEED with idx=0, match_count cleared, busy=1 next cycle.
  - If load_we and start occur together, the write takes effect and the pass starts. Byte 0 uses the new value when load_addr=0.
- FEED:
  - Each cycle: det_data=mem[idx], det_ack=1.
  - If det_found=0: idx increments.
  - When the byte at idx=DEPTH-1 is presented and det_found=0 → DRAIN. No wrap-around; idx never exceeds DEPTH-1.
  - If det_found=1: det_data is held and idx is not advanced. last_match_idx is set to the index of the currently presented byte. match_count is incremented (saturating), match_valid pulses, then → ACK_LOW.
- ACK_LOW:
  - det_ack=0 for exactly ACK_LOW_CYCLES cycles; det_data is held.
  - det_found is ignored here and cannot cause a double count.
  - Then → RECOVER.
- RECOVER:
  - One cycle with det_ack=1 and det_data held; idx is not advanced.
  - Then → FEED, unless the held byte was index DEPTH-1, in which case → DRAIN.
- DRAIN:
  - det_ack=1, det_data held at the last byte, for DRAIN_CYCLES cycles.
  - det_found=1 here is logged as a match: last_match_idx=DEPTH-1, then ACK_LOW → RECOVER → DRAIN restarts its cycle count.
  - On expiry → DONE.
- DONE:
  - done=1 for one cycle, busy=0, det_ack=0 → IDLE.
  - match_count and last_match_idx hold until the next start or reset.
- start while busy=1 is ignored. load_we while busy=1 is ignored; the buffer is unchanged.
- Latency:
  - Byte k is presented on cycle k+1 after the start edge when no matches occur.
  - A full match-free pass asserts done on cycle DEPTH+DRAIN_CYCLES+1.
  - Each match adds ACK_LOW_CYCLES+1 cycles.

Test Plan:
- Reset then idle: reset_sync=1 for 3 cycles, then release → all outputs 0. Pulse start with det_found tied 0 → det_data steps through mem[0..31]; done pulses on cycle 35 after start; match_count=0.
- Load and readback: write mem[i]=i^8'hA5 for i=0..31, then start → det_data sequence A5,A4,A7,… matches exactly, one byte per cycle.
- Single match: drive det_found=1 for one cycle while byte 10 is presented → match_valid pulse; last_match_idx=10; match_count=1; det_ack low exactly 2 cycles; byte 10 held 4 cycles total; next new byte is 11; done on cycle 38.
- Back-to-back and saturation:
  - det_found held 1 continuously during ACK_LOW → still one count per stall.
  - With CNT_W=2, force 5 matches → match_count=3.
- Boundary match: det_found=1 at byte 31, and again during DRAIN → match_count=2; last_match_idx=31 both times; done only after DRAIN completes.
- Abort and ignore:
  - Assert reset_sync at byte 15 → outputs zero asynchronously; no done pulse.
  - After restart, start and load_we pulses while busy → no effect on idx or buffer.
